// File: rtl/regfile_scoreboard_if.sv
// ============================================================================
// regfile_scoreboard_if : read, write and scoreboard-set bus of the GPR array
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_busy1;
  logic              rd_busy2;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              sb_set_en;
  logic [ADDR_W-1:0] sb_set_addr;
  logic [ADDR_W:0]   busy_cnt;

  modport master (
    output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
    input  rd_data1, rd_data2, rd_busy1, rd_busy2, busy_cnt
  );

  modport slave (
    input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
    output rd_data1, rd_data2, rd_busy1, rd_busy2, busy_cnt
  );
endinterface

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// regfile_scoreboard : 2R/1W register file with per-register busy scoreboard.
// Optional write-through forwarding enabled by defining REGFILE_BYPASS_EN.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_scoreboard_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic [CNT_W-1:0]  busy_cnt_q;
  logic [CNT_W-1:0]  busy_cnt_nxt;
  logic              wr_ok;
  logic              set_ok;
  logic [DATA_W-1:0] arr_data1;
  logic [DATA_W-1:0] arr_data2;
  logic              arr_busy1;
  logic              arr_busy2;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  assign wr_ok  = bus.wr_en     && !is_zero(bus.wr_addr);
  assign set_ok = bus.sb_set_en && !is_zero(bus.sb_set_addr);

  // Set is applied after the clear so a same-cycle issue to the written register keeps it busy
  always_comb begin
    busy_nxt = busy;
    if (wr_ok) begin
      busy_nxt[bus.wr_addr] = 1'b0;
    end
    if (set_ok) begin
      busy_nxt[bus.sb_set_addr] = 1'b1;
    end
  end

  always_comb begin
    busy_cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy_cnt_nxt = busy_cnt_nxt + CNT_W'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_cnt_q <= busy_cnt_nxt;
    end
  end

  assign arr_data1 = is_zero(bus.rd_addr1) ? '0 : regs[bus.rd_addr1];
  assign arr_data2 = is_zero(bus.rd_addr2) ? '0 : regs[bus.rd_addr2];
  assign arr_busy1 = !is_zero(bus.rd_addr1) && busy[bus.rd_addr1];
  assign arr_busy2 = !is_zero(bus.rd_addr2) && busy[bus.rd_addr2];

`ifdef REGFILE_BYPASS_EN
  logic hit1;
  logic hit2;
  logic set_on_wr;

  // Forwarding is suppressed while reset is held so reads stay at zero
  assign hit1      = rst_n && wr_ok && (bus.rd_addr1 == bus.wr_addr);
  assign hit2      = rst_n && wr_ok && (bus.rd_addr2 == bus.wr_addr);
  assign set_on_wr = set_ok && (bus.sb_set_addr == bus.wr_addr);

  assign bus.rd_data1 = hit1 ? bus.wr_data : arr_data1;
  assign bus.rd_data2 = hit2 ? bus.wr_data : arr_data2;
  assign bus.rd_busy1 = hit1 ? set_on_wr   : arr_busy1;
  assign bus.rd_busy2 = hit2 ? set_on_wr   : arr_busy2;
`else
  assign bus.rd_data1 = arr_data1;
  assign bus.rd_data2 = arr_data2;
  assign bus.rd_busy1 = arr_busy1;
  assign bus.rd_busy2 = arr_busy2;
`endif

  assign bus.busy_cnt = busy_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
// ============================================================================
// tb_regfile_scoreboard : directed and random checks of regfile_scoreboard
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_scoreboard;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int DEPTH    = 2 ** ADDR_W;
  localparam bit ZERO_REG = 1'b1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  regfile_scoreboard #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [DATA_W-1:0] m_regs [DEPTH];
  bit                m_busy [DEPTH];

  function automatic bit zr(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == 0);
  endfunction

  function automatic logic [ADDR_W:0] m_count();
    int c = 0;
    foreach (m_busy[i]) c += int'(m_busy[i]);
    return (ADDR_W+1)'(c);
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
    if (zr(a)) return '0;
`ifdef REGFILE_BYPASS_EN
    if (rst_n && bus.wr_en && bus.wr_addr == a) return bus.wr_data;
`endif
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [ADDR_W-1:0] a);
    if (zr(a)) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (rst_n && bus.wr_en && bus.wr_addr == a)
      return bus.sb_set_en && bus.sb_set_addr == a;
`endif
    return m_busy[a];
  endfunction

  task automatic model_reset();
    foreach (m_regs[i]) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic idle();
    bus.wr_en     = 1'b0;
    bus.sb_set_en = 1'b0;
  endtask

  // One clock edge; the model applies the edge's write and set
  task automatic step();
    @(posedge clk);
    if (rst_n) begin
      if (bus.wr_en && !zr(bus.wr_addr)) begin
        m_regs[bus.wr_addr] = bus.wr_data;
        m_busy[bus.wr_addr] = 1'b0;
      end
      if (bus.sb_set_en && !zr(bus.sb_set_addr)) m_busy[bus.sb_set_addr] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic drive(input bit we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                       input bit se, input logic [ADDR_W-1:0] sa);
    bus.wr_en       = we;
    bus.wr_addr     = wa;
    bus.wr_data     = wd;
    bus.sb_set_en   = se;
    bus.sb_set_addr = sa;
  endtask

  task automatic test_reset();
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    bus.rd_addr1 = 5'd5;
    bus.rd_addr2 = 5'd7;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    vectors++;
    if (bus.busy_cnt !== '0 || bus.rd_data1 !== '0 || bus.rd_busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: cnt=%0d data1=%h busy2=%b required 0/0/0",
               bus.busy_cnt, bus.rd_data1, bus.rd_busy2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'd5, 32'h0000_DEAD, 1'b1, 5'd7);
    step();
    idle();
    #1;
    vectors++;
    if (bus.rd_data1 !== 32'h0000_DEAD || bus.rd_busy2 !== 1'b1 || bus.busy_cnt !== 6'd1) begin
      miscompares++;
      $display("FAIL pre_reset_write: data1=%h busy2=%b cnt=%0d required DEAD/1/1",
               bus.rd_data1, bus.rd_busy2, bus.busy_cnt);
    end
    drive(1'b1, 5'd5, 32'h0000_BEEF, 1'b1, 5'd9);
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.rd_data1 !== '0 || bus.rd_busy2 !== 1'b0 || bus.busy_cnt !== '0) begin
      miscompares++;
      $display("FAIL async_reset: data1=%h busy2=%b cnt=%0d required 0/0/0",
               bus.rd_data1, bus.rd_busy2, bus.busy_cnt);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.rd_data1 !== '0 || bus.busy_cnt !== '0) begin
      miscompares++;
      $display("FAIL write_lost_in_reset: data1=%h cnt=%0d required 0/0",
               bus.rd_data1, bus.busy_cnt);
    end
  endtask

  task automatic test_basic();
    drive(1'b1, 5'd2, 32'd13, 1'b0, 5'd0);
    step();
    drive(1'b1, 5'd3, 32'd28, 1'b0, 5'd0);
    step();
    idle();
    bus.rd_addr1 = 5'd2;
    bus.rd_addr2 = 5'd3;
    #1;
    vectors++;
    if (bus.rd_data1 !== 32'd13 || bus.rd_data2 !== 32'd28) begin
      miscompares++;
      $display("FAIL basic_rw: data1=%0d data2=%0d required 13/28", bus.rd_data1, bus.rd_data2);
    end
    bus.rd_addr1 = 5'd3;
    #1;
    vectors++;
    if (bus.rd_data1 !== 32'd28 || bus.rd_data2 !== 32'd28) begin
      miscompares++;
      $display("FAIL same_addr_read: data1=%0d data2=%0d required 28/28", bus.rd_data1, bus.rd_data2);
    end
  endtask

  task automatic test_zero_reg();
    logic [ADDR_W:0] c0;
    c0 = m_count();
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0);
    step();
    idle();
    bus.rd_addr1 = 5'd0;
    bus.rd_addr2 = 5'd0;
    #1;
    vectors++;
    if (bus.rd_data1 !== (ZERO_REG ? 32'h0 : 32'hFFFF_FFFF) ||
        bus.rd_busy2 !== (ZERO_REG ? 1'b0 : 1'b1) ||
        bus.busy_cnt !== (ZERO_REG ? c0 : c0 + 1'b1)) begin
      miscompares++;
      $display("FAIL zero_reg: data=%h busy=%b cnt=%0d (cnt before %0d)",
               bus.rd_data1, bus.rd_busy2, bus.busy_cnt, c0);
    end
  endtask

  task automatic test_scoreboard();
    logic [ADDR_W:0] c0;
    c0 = m_count();
    bus.rd_addr1 = 5'd4;
    drive(1'b0, 5'd0, '0, 1'b1, 5'd4);
    step();
    idle();
    #1;
    vectors++;
    if (bus.rd_busy1 !== 1'b1 || bus.busy_cnt !== c0 + 1'b1) begin
      miscompares++;
      $display("FAIL sb_set: busy=%b cnt=%0d required 1/%0d", bus.rd_busy1, bus.busy_cnt, c0 + 1'b1);
    end
    drive(1'b1, 5'd4, 32'h55, 1'b0, 5'd0);
    step();
    idle();
    #1;
    vectors++;
    if (bus.rd_busy1 !== 1'b0 || bus.rd_data1 !== 32'h55 || bus.busy_cnt !== c0) begin
      miscompares++;
      $display("FAIL sb_clear: busy=%b data=%h cnt=%0d required 0/55/%0d",
               bus.rd_busy1, bus.rd_data1, bus.busy_cnt, c0);
    end
    drive(1'b1, 5'd4, 32'h66, 1'b1, 5'd4);
    step();
    idle();
    #1;
    vectors++;
    if (bus.rd_busy1 !== 1'b1 || bus.rd_data1 !== 32'h66 || bus.busy_cnt !== c0 + 1'b1) begin
      miscompares++;
      $display("FAIL set_wins: busy=%b data=%h cnt=%0d required 1/66/%0d",
               bus.rd_busy1, bus.rd_data1, bus.busy_cnt, c0 + 1'b1);
    end
    drive(1'b1, 5'd4, 32'h77, 1'b0, 5'd0);
    step();
    idle();
  endtask

  task automatic test_bypass();
    logic [DATA_W-1:0] old;
    old = m_regs[9];
    bus.rd_addr1 = 5'd9;
    bus.rd_addr2 = 5'd9;
    drive(1'b1, 5'd9, 32'h1234, 1'b0, 5'd0);
    #1;
    vectors++;
`ifdef REGFILE_BYPASS_EN
    if (bus.rd_data1 !== 32'h1234 || bus.rd_busy1 !== 1'b0) begin
`else
    if (bus.rd_data1 !== old || bus.rd_busy1 !== m_busy[9]) begin
`endif
      miscompares++;
      $display("FAIL bypass_same_cycle: data=%h busy=%b (old %h)", bus.rd_data1, bus.rd_busy1, old);
    end
    step();
    drive(1'b1, 5'd9, 32'h5678, 1'b1, 5'd9);
    #1;
    vectors++;
    if (bus.rd_data2 !== exp_data(5'd9) || bus.rd_busy2 !== exp_busy(5'd9)) begin
      miscompares++;
      $display("FAIL bypass_with_set: data=%h busy=%b required %h/%b",
               bus.rd_data2, bus.rd_busy2, exp_data(5'd9), exp_busy(5'd9));
    end
    step();
    idle();
    #1;
    vectors++;
    if (bus.rd_data1 !== 32'h5678 || bus.rd_busy1 !== 1'b1) begin
      miscompares++;
      $display("FAIL bypass_next_cycle: data=%h busy=%b required 5678/1", bus.rd_data1, bus.rd_busy1);
    end
  endtask

  task automatic test_fill();
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, 5'd0, '0, 1'b1, ADDR_W'(a));
      step();
    end
    idle();
    drive(1'b0, 5'd0, '0, 1'b1, 5'd1);
    step();
    idle();
    #1;
    vectors++;
    if (bus.busy_cnt !== (ZERO_REG ? 6'(DEPTH - 1) : 6'(DEPTH))) begin
      miscompares++;
      $display("FAIL fill_count: cnt=%0d required %0d", bus.busy_cnt, ZERO_REG ? DEPTH - 1 : DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b1, ADDR_W'(a), 32'(a * 3 + 1), 1'b0, 5'd0);
      step();
      idle();
      #1;
      vectors++;
      if (bus.busy_cnt !== m_count()) begin
        miscompares++;
        $display("FAIL drain_count[%0d]: cnt=%0d required %0d", a, bus.busy_cnt, m_count());
      end
    end
    vectors++;
    if (bus.busy_cnt !== '0) begin
      miscompares++;
      $display("FAIL drain_empty: cnt=%0d required 0", bus.busy_cnt);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [ADDR_W-1:0] ra1, ra2, wa, sa;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      ra1 = narrow ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
      ra2 = narrow ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
      wa  = narrow ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
      sa  = narrow ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom);
      bus.rd_addr1 = ra1;
      bus.rd_addr2 = ra2;
      drive($urandom_range(0, 1) == 1, wa, $urandom, $urandom_range(0, 2) == 0, sa);
      #1;
      vectors++;
      if (bus.rd_data1 !== exp_data(ra1) || bus.rd_data2 !== exp_data(ra2) ||
          bus.rd_busy1 !== exp_busy(ra1) || bus.rd_busy2 !== exp_busy(ra2) ||
          bus.busy_cnt !== m_count()) begin
        miscompares++;
        $display("FAIL random[%0d]: d1=%h/%h d2=%h/%h b1=%b/%b b2=%b/%b cnt=%0d/%0d (actual/required)",
                 n, bus.rd_data1, exp_data(ra1), bus.rd_data2, exp_data(ra2),
                 bus.rd_busy1, exp_busy(ra1), bus.rd_busy2, exp_busy(ra2),
                 bus.busy_cnt, m_count());
      end
      step();
    end
    idle();
  endtask

  initial begin
    bus.rd_addr1 = '0;
    bus.rd_addr2 = '0;
    drive(1'b0, 5'd0, '0, 1'b0, 5'd0);
    test_reset();
    test_basic();
    test_zero_reg();
    test_scoreboard();
    test_bypass();
    test_fill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
